mem_store_unit: RTL and testbench
=================================

# mem_store_unit

Write-side counterpart of the load-extension path in the M stage. Accepts store requests (byte address, access length, register data) from the pipeline, checks alignment, builds word-aligned byte enables and lane-replicated write data, and buffers them in a small FIFO. Entries drain to the data-memory bus with a request/acknowledge handshake, so the pipeline never stalls on a single slow write.

## Interface
- DEPTH, 2: FIFO entries; power of two, at least 2.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- st_valid  in  1  store request present.
- st_ready  out  1  unit can accept; equals !full.
- st_addr  in  32  byte address.
- st_len  in  8  access length; one of `MemLenW`, `MemLenH`, `MemLenB`.
- st_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- st_err  out  1  combinational; request is misaligned or has an unknown length.
- bus_req  out  1  head entry valid; equals !empty.
- bus_addr  out  32  word address of head entry, bits [1:0] = 0.
- bus_be  out  4  byte enables of head entry.
- bus_wdata  out  32  lane-replicated data of head entry.
- bus_ack  in  1  bus consumed head entry this cycle.
- empty  out  1  FIFO holds no entry; the pipeline uses it as the drain-complete / fence indication.

## Operation
- Accept: a request is accepted when st_valid && st_ready && !st_err.
- Error handling: when st_err=1, nothing is enqueued and the request is dropped. The pipeline raises AdES.
- st_err conditions:
  - `MemLenW` with st_addr[1:0] != 0.
  - `MemLenH` with st_addr[0] = 1.
  - Any other st_len value.
- st_err depends only on st_valid, st_addr and st_len, and is 0 when st_valid=0.
- Formatting, all cases use bus_addr = {st_addr[31:2], 2'b00}:
  - W: be=4'b1111; wdata=st_data.
  - H: addr[1]=0 gives be=4'b0011; addr[1]=1 gives be=4'b1100. wdata={st_data[15:0], st_data[15:0]}.
  - B: be=4'b0001 << st_addr[1:0]; wdata={4{st_data[7:0]}}.
- FIFO behaviour:
  - Circular buffer with read/write pointers of log2(DEPTH)+1 bits.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH.
- Pop: on bus_ack && bus_req. bus_ack while empty is ignored, with no pointer movement.
- Simultaneous push and pop: allowed when the FIFO is not full, and occupancy is unchanged. When full, st_ready=0 regardless of bus_ack, so there is no same-cycle refill.
- Ordering: entries issue strictly in acceptance order.
- Head-entry stability: the head entry's fields stay stable while bus_req=1 and bus_ack=0.

## Timing
- Latency: an accepted request is visible on bus_req/bus_addr/bus_be/bus_wdata on the next cycle, provided the FIFO was empty.
- bus_* outputs are driven from registers or the FIFO array, with no combinational path from st_* to bus_*.
- st_ready and empty are functions of the pointers only.
- Throughput: one accept per cycle and one drain per cycle.
- Reset values:
  - Pointers = 0, so bus_req=0, empty=1, st_ready=1.
  - bus_addr, bus_be, bus_wdata = 0.
  - st_err follows its inputs.
- Reset mid-operation: all buffered stores are discarded, and no bus_req is issued on the first cycle after reset deasserts.

## Structure
- `MemLenW`, `MemLenH`, `MemLenB` come from the shared constants file; no new length codes are introduced.
- A combinational sub-module `mem_be_gen` (addr[1:0], len, data → be, wdata, err) holds the formatting and alignment check.
- The top level holds the FIFO, pointers and handshake.

## Test plan
- SB to 0x0000_1003 with data 0x1234_56AB, bus_ack held high → next cycle bus_addr=0x0000_1000, be=4'b1000, wdata=0xABAB_ABAB; empty=1 one cycle later.
- SH to 0x0000_2002 with data 0xFFFF_BEEF → be=4'b1100, wdata=0xBEEF_BEEF. SH to 0x0000_2001 → st_err=1 and no enqueue (empty stays 1).
- SW to 0x0000_3004 with data 0xDEAD_BEEF → be=4'b1111, wdata=0xDEAD_BEEF. SW to 0x0000_3006 → st_err=1.
- Fill and order, with bus_ack=0 and DEPTH=2:
  - Two SWs → st_ready=0 and the third request is not accepted.
  - Then pulse bus_ack → the entries drain in order and st_ready returns to 1 after the first pop.
  - Pointer wrap-around: after 10 mixed push/pop cycles, FIFO order is intact.
- Simultaneous push and pop with occupancy 1 → occupancy stays 1 and the head advances to the new entry's predecessor order correctly.
- Assert reset with 2 entries buffered → bus_req=0, empty=1, st_ready=1 immediately and asynchronously. bus_ack after release has no effect.

Source files
------------

// File: rtl/mem_store_unit_pkg.sv
// Shared constants and types for the M-stage store path.
package mem_store_unit_pkg;

  // Access-length codes shared with the load-extension path.
  localparam logic [7:0] MemLenB = 8'h00;
  localparam logic [7:0] MemLenH = 8'h01;
  localparam logic [7:0] MemLenW = 8'h02;

  // One buffered store: word address, byte enables and lane-replicated data.
  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } st_entry_t;

  // Single-byte enable for a byte offset within the word.
  function automatic logic [3:0] byte_be(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/mem_be_gen.sv
// Store formatting: alignment check, byte-enable generation and lane replication.
module mem_be_gen
  import mem_store_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [7:0]  len,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        err
);

  // Decode length into enables/data; unknown lengths flag an error.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    err   = 1'b0;
    case (len)
      MemLenW: begin
        be    = 4'b1111;
        wdata = data;
        err   = (addr_lo != 2'b00);
      end
      MemLenH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {data[15:0], data[15:0]};
        err   = addr_lo[0];
      end
      MemLenB: begin
        be    = byte_be(addr_lo);
        wdata = {4{data[7:0]}};
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store buffer: formats accepted stores and drains them in order to the data bus.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2  // power of two, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [7:0]  st_len,
  input  logic [31:0] st_data,
  output logic        st_err,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, rptr_q;
  st_entry_t     mem_q [DEPTH];
  st_entry_t     head;
  logic [3:0]    gen_be;
  logic [31:0]   gen_wdata;
  logic          gen_err;
  logic          full;
  logic          push;
  logic          pop;

  mem_be_gen u_be_gen (
    .addr_lo (st_addr[1:0]),
    .len     (st_len),
    .data    (st_data),
    .be      (gen_be),
    .wdata   (gen_wdata),
    .err     (gen_err)
  );

  // Occupancy flags from pointers only; extra MSB distinguishes full from empty.
  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    st_ready = !full;
    st_err   = st_valid && gen_err;
    push     = st_valid && !full && !gen_err;
    pop      = bus_ack && !empty;
  end

  // Pointer update; natural PW-bit overflow gives the modulo-2*DEPTH wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Entry storage; cleared on reset so the bus outputs read back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= '{waddr: st_addr[31:2], be: gen_be, wdata: gen_wdata};
    end
  end

  // Bus side reads the head slot directly; no path from st_* to bus_*.
  always_comb begin
    head      = mem_q[rptr_q[AW-1:0]];
    bus_req   = !empty;
    bus_addr  = {head.waddr, 2'b00};
    bus_be    = head.be;
    bus_wdata = head.wdata;
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: vector table plus multi-cycle sequences.
module tb_mem_store_unit;
  import mem_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [7:0]  st_len;
  logic [31:0] st_data;
  logic        st_err;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        empty;

  int total = 0;
  int bad   = 0;

  mem_store_unit #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_len    (st_len),
    .st_data   (st_data),
    .st_err    (st_err),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [7:0] l,
                       input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_len   = l;
    st_data  = d;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] q [$];
  logic [11:0] push_pat;
  logic [11:0] ack_pat;

  initial begin
    vecs[0]  = '{32'h0000_1003, MemLenB, 32'h1234_56AB, 1'b0, 4'b1000, 32'hABAB_ABAB};
    vecs[1]  = '{32'h0000_1000, MemLenB, 32'h0000_0011, 1'b0, 4'b0001, 32'h1111_1111};
    vecs[2]  = '{32'h0000_1001, MemLenB, 32'hFFFF_FF5A, 1'b0, 4'b0010, 32'h5A5A_5A5A};
    vecs[3]  = '{32'h0000_2002, MemLenH, 32'hFFFF_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF};
    vecs[4]  = '{32'h0000_2000, MemLenH, 32'h0000_1234, 1'b0, 4'b0011, 32'h1234_1234};
    vecs[5]  = '{32'h0000_2001, MemLenH, 32'hFFFF_BEEF, 1'b1, 4'b0000, 32'h0};
    vecs[6]  = '{32'h0000_2003, MemLenH, 32'h0000_BEEF, 1'b1, 4'b0000, 32'h0};
    vecs[7]  = '{32'h0000_3004, MemLenW, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vecs[8]  = '{32'h0000_3006, MemLenW, 32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0};
    vecs[9]  = '{32'h0000_3001, MemLenW, 32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0};
    vecs[10] = '{32'h0000_3000, 8'h03,   32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0};
    vecs[11] = '{32'h0000_3000, 8'hFF,   32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0};

    // Reset state
    reset = 1'b1;
    bus_ack = 1'b0;
    drive(1'b0, 32'h0, MemLenW, 32'h0);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_empty", empty, 1);
    check("rst_st_ready", st_ready, 1);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    // st_err is gated by st_valid
    drive(1'b0, 32'h0000_3006, MemLenW, 32'h0);
    #1 check("err_no_valid", st_err, 0);

    // Formatting table: one store, check, then drain
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].addr, vecs[i].len, vecs[i].data);
      #1 check($sformatf("v%0d_err", i), st_err, vecs[i].err);
      @(negedge clk);
      st_valid = 1'b0;
      if (vecs[i].err) begin
        check($sformatf("v%0d_no_enq", i), empty, 1);
      end else begin
        check($sformatf("v%0d_req", i), bus_req, 1);
        check($sformatf("v%0d_addr", i), bus_addr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("v%0d_be", i), bus_be, vecs[i].be);
        check($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].wdata);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check($sformatf("v%0d_drained", i), empty, 1);
      end
    end

    // SB with bus_ack held high: ack while empty is ignored, then pops next cycle
    @(negedge clk);
    drive(1'b1, 32'h0000_1003, MemLenB, 32'h1234_56AB);
    bus_ack = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    check("ackhi_req", bus_req, 1);
    check("ackhi_addr", bus_addr, 32'h0000_1000);
    check("ackhi_be", bus_be, 4'b1000);
    check("ackhi_wdata", bus_wdata, 32'hABAB_ABAB);
    @(negedge clk);
    check("ackhi_empty", empty, 1);
    bus_ack = 1'b0;

    // Fill to DEPTH, third request refused, then drain in order
    @(negedge clk);
    drive(1'b1, 32'h0000_4000, MemLenW, 32'h1111_1111);
    @(negedge clk);
    drive(1'b1, 32'h0000_4004, MemLenW, 32'h2222_2222);
    @(negedge clk);
    check("fill_ready0", st_ready, 0);
    drive(1'b1, 32'h0000_4008, MemLenW, 32'h3333_3333);
    @(negedge clk);
    st_valid = 1'b0;
    check("fill_head_stable", bus_wdata, 32'h1111_1111);
    check("fill_still_full", st_ready, 0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("fill_ready1", st_ready, 1);
    check("fill_order_addr", bus_addr, 32'h0000_4004);
    check("fill_order_wdata", bus_wdata, 32'h2222_2222);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("fill_third_dropped", empty, 1);

    // Simultaneous push and pop at occupancy 1
    drive(1'b1, 32'h0000_5000, MemLenW, 32'hAAAA_0001);
    @(negedge clk);
    drive(1'b1, 32'h0000_5004, MemLenW, 32'hAAAA_0002);
    bus_ack = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    bus_ack  = 1'b0;
    check("pp_not_empty", empty, 0);
    check("pp_ready", st_ready, 1);
    check("pp_head", bus_wdata, 32'hAAAA_0002);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("pp_drained", empty, 1);

    // Mixed push/pop against a queue model; pointers wrap several times
    push_pat = 12'b1101_1111_0111;
    ack_pat  = 12'b0111_0110_1110;
    begin
      int n = 0;
      for (int i = 0; i < 12; i++) begin
        logic acc, pp;
        logic [31:0] d;
        d = 32'hC0DE_0000 + 32'(n);
        drive(push_pat[i], 32'h0000_6000 + 32'(4 * n), MemLenW, d);
        bus_ack = ack_pat[i];
        acc = push_pat[i] && (q.size() < 2);
        pp  = ack_pat[i] && (q.size() > 0);
        #1 check($sformatf("mix%0d_ready", i), st_ready, (q.size() < 2) ? 1 : 0);
        @(negedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
          q.push_back(d);
          n++;
        end
        check($sformatf("mix%0d_empty", i), empty, (q.size() == 0) ? 1 : 0);
        if (q.size() > 0) check($sformatf("mix%0d_head", i), bus_wdata, q[0]);
      end
    end
    st_valid = 1'b0;
    bus_ack  = 1'b1;
    for (int i = 0; i < 4 && !empty; i++) @(negedge clk);
    bus_ack = 1'b0;
    check("mix_drain_done", empty, 1);

    // Asynchronous reset with two entries buffered
    drive(1'b1, 32'h0000_7000, MemLenW, 32'h7777_0000);
    @(negedge clk);
    drive(1'b1, 32'h0000_7004, MemLenW, 32'h7777_0004);
    @(negedge clk);
    st_valid = 1'b0;
    check("pre_rst_full", st_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_bus_req", bus_req, 0);
    check("arst_empty", empty, 1);
    check("arst_st_ready", st_ready, 1);
    check("arst_bus_be", bus_be, 0);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_req", bus_req, 0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("post_rst_ack_empty", empty, 1);
    drive(1'b1, 32'h0000_8008, MemLenH, 32'h0000_CAFE);
    @(negedge clk);
    st_valid = 1'b0;
    check("post_rst_push_addr", bus_addr, 32'h0000_8008);
    check("post_rst_push_be", bus_be, 4'b0011);
    check("post_rst_push_wdata", bus_wdata, 32'hCAFE_CAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
